// File: rtl/cby_param.sv
`default_nettype none
// ============================================================================
// Module      : cby_param
// Description : Parameterised Y-direction connection block.
//               - Y-channel tracks pass straight through (bottom->top, top->bottom).
//               - NUM_IPIN muxes of MUX_SIZE inputs drive the grid input pins.
//               - Mux selects come from a serial shadow chain.
//               - The chain contents are committed to the active selects when
//                 config_enable falls, but only if the bit count is exact.
//               Optional feature macro: CBY_CFG_PARITY_EN
//                 Adds one trailing even-parity bit to the chain and checks it
//                 at commit.
// Revision    : 1.0 - initial release
// ============================================================================
module cby_param #(
  parameter int CHAN_W   = 12,
  parameter int NUM_IPIN = 9,
  parameter int MUX_SIZE = 6
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                config_enable,
  input  logic                ccff_head,
  input  logic [CHAN_W-1:0]   chany_bottom_in,
  input  logic [CHAN_W-1:0]   chany_top_in,
  output logic [CHAN_W-1:0]   chany_top_out,
  output logic [CHAN_W-1:0]   chany_bottom_out,
  output logic [NUM_IPIN-1:0] ipin_out,
  output logic                ccff_tail,
  output logic                cfg_active,
  output logic                cfg_err
);

  localparam int C_SEL_W = $clog2(MUX_SIZE);
  localparam int C_L     = NUM_IPIN * C_SEL_W;
`ifdef CBY_CFG_PARITY_EN
  localparam int C_CHAIN_LEN = C_L + 1;
`else
  localparam int C_CHAIN_LEN = C_L;
`endif
  // One value past the chain length flags an over-shifted session.
  localparam int C_CNT_MAX = C_CHAIN_LEN + 1;
  localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);

  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);
  localparam logic [C_CNT_W-1:0] C_CNT_SAT  = C_CNT_W'(C_CNT_MAX);
  localparam logic [C_CNT_W-1:0] C_CNT_DONE = C_CNT_W'(C_CHAIN_LEN);
  localparam logic [C_SEL_W:0]   C_MUX_LIM  = (C_SEL_W+1)'(MUX_SIZE);

  logic [C_CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic [C_L-1:0]         active_sel_q, active_sel_d;
  logic [C_CNT_W-1:0]     cnt_q, cnt_d;
  logic                   en_q, en_d;
  logic                   cfg_active_q, cfg_active_d;
  logic                   cfg_err_q, cfg_err_d;

  logic                   w_start;
  logic                   w_commit;
  logic                   w_parity_ok;
  logic [C_L-1:0]         w_sel_data;

  // Tracks are plain wires through the block.
  assign chany_top_out    = chany_bottom_in;
  assign chany_bottom_out = chany_top_in;

  assign ccff_tail  = shadow_q[C_CHAIN_LEN-1];
  assign cfg_active = cfg_active_q;
  assign cfg_err    = cfg_err_q;

  assign w_start  = config_enable & ~en_q;
  assign w_commit = en_q & ~config_enable;

  // Select fields are the first L bits shifted in; with parity the last bit
  // shifted in (bit 0) is the parity bit and sits below the select fields.
  assign w_sel_data = shadow_q[C_CHAIN_LEN-1 -: C_L];

`ifdef CBY_CFG_PARITY_EN
  assign w_parity_ok = ~(^shadow_q);
`else
  assign w_parity_ok = 1'b1;
`endif

  // Next-state logic for shift chain, session counter and commit.
  always_comb begin
    shadow_d     = shadow_q;
    active_sel_d = active_sel_q;
    cnt_d        = cnt_q;
    en_d         = config_enable;
    cfg_active_d = cfg_active_q;
    cfg_err_d    = cfg_err_q;

    if (config_enable) begin
      shadow_d = {shadow_q[C_CHAIN_LEN-2:0], ccff_head};
      if (w_start) begin
        cnt_d = C_CNT_ONE;
      end else if (cnt_q != C_CNT_SAT) begin
        cnt_d = cnt_q + C_CNT_ONE;
      end
    end

    if (w_commit) begin
      if ((cnt_q == C_CNT_DONE) && w_parity_ok) begin
        active_sel_d = w_sel_data;
        cfg_active_d = 1'b1;
        cfg_err_d    = 1'b0;
      end else begin
        cfg_err_d    = 1'b1;
      end
    end
  end

  // State registers; reset overrides any shift or commit on the same edge.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      shadow_q     <= '0;
      active_sel_q <= '0;
      cnt_q        <= '0;
      en_q         <= 1'b0;
      cfg_active_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_sel_q <= active_sel_d;
      cnt_q        <= cnt_d;
      en_q         <= en_d;
      cfg_active_q <= cfg_active_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  // Input pin muxes: fixed low track pairs plus one staggered pair per pin.
  generate
    for (genvar k = 0; k < NUM_IPIN; k++) begin : g_ipin
      localparam int C_J = (k + MUX_SIZE/2 - 1) % CHAN_W;

      logic [MUX_SIZE-1:0] w_in;
      logic [C_SEL_W-1:0]  w_sel;

      for (genvar t = 0; t < MUX_SIZE/2 - 1; t++) begin : g_pair
        assign w_in[2*t]   = chany_bottom_in[t];
        assign w_in[2*t+1] = chany_top_in[t];
      end

      assign w_in[MUX_SIZE-2] = chany_bottom_in[C_J];
      assign w_in[MUX_SIZE-1] = chany_top_in[C_J];

      assign w_sel = active_sel_q[k*C_SEL_W +: C_SEL_W];

      // Out-of-range selects and an unconfigured block both drive 0.
      assign ipin_out[k] = (cfg_active_q && ({1'b0, w_sel} < C_MUX_LIM))
                           ? w_in[w_sel] : 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/cby_param.md
CBY_PARAM -- requirements
Module: cby_param

Interface
REQ-001 SHALL provide parameter CHAN_W, default 12: number of tracks per direction in the Y channel.
REQ-002 SHALL provide parameter NUM_IPIN, default 9: number of grid input pins driven.
REQ-003 SHALL provide parameter MUX_SIZE, default 6, even, range 4..2*CHAN_W: inputs per IPIN mux; SEL_W = clog2(MUX_SIZE); L = NUM_IPIN*SEL_W.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clock prog_clk, reset pReset.
REQ-005 prog_clk  input  1  configuration and state clock.
REQ-006 pReset  input  1  synchronous active-high reset.
REQ-007 config_enable  input  1  high = shift one config bit per prog_clk edge.
REQ-008 ccff_head  input  1  serial configuration data in.
REQ-009 chany_bottom_in, chany_top_in  input  CHAN_W each  channel tracks entering.
REQ-010 chany_top_out, chany_bottom_out  output  CHAN_W each  pass-through tracks.
REQ-011 ipin_out  output  NUM_IPIN  grid input pin drives.
REQ-012 ccff_tail  output  1  serial configuration data out, last shadow bit.
REQ-013 cfg_active  output  1  committed configuration valid.
REQ-014 cfg_err  output  1  sticky error from the last configuration session.

Function
REQ-015 chany_top_out SHALL equal chany_bottom_in, and chany_bottom_out SHALL equal chany_top_in, combinationally at all times, reset included.
REQ-016 Mux k input list SHALL be {bottom[t], top[t]} for t = 0..MUX_SIZE/2-2, followed by {bottom[j], top[j]}, j = (k + MUX_SIZE/2 - 1) mod CHAN_W; input index 0 is bottom[0].
REQ-017 ipin_out[k] SHALL be combinational: input[active_sel[k]] when cfg_active=1; 0 when cfg_active=0 or active_sel[k] >= MUX_SIZE.
REQ-018 Shadow chain SHALL be an L-bit shift register (L+1 bits with parity, REQ-029); on each edge with config_enable=1, ccff_head enters bit 0 and every bit advances one place; ccff_tail = last bit.
REQ-019 Mux k select SHALL occupy shadow bits [k*SEL_W +: SEL_W], LSB at the lower index.
REQ-020 en_q SHALL register config_enable; a session starts on an edge with en_q=0 and config_enable=1; bit counter SHALL load 1 on that edge.
REQ-021 Each later shift SHALL increment the counter, saturating at L+1; counter value L+1 means over-shift.
REQ-022 Commit edge = en_q=1 and config_enable=0: if count == chain length and the check passes, active_sel <= shadow, cfg_active <= 1, cfg_err <= 0; otherwise active_sel and cfg_active hold and cfg_err <= 1.
REQ-023 Committed values SHALL appear on ipin_out the cycle after the commit edge; active_sel SHALL never change during shifting.
REQ-024 Starting a new session SHALL NOT clear cfg_active or active_sel; cfg_err SHALL hold until the next commit edge or reset.
REQ-025 A session aborted by pReset SHALL commit nothing.

Reset
REQ-026 pReset SHALL clear the shadow chain, active_sel, counter, en_q, cfg_active and cfg_err, giving ipin_out=0 and ccff_tail=0 on the next edge.
REQ-027 pReset SHALL take priority over config_enable on the same edge.

Configuration
REQ-028 Macro CBY_CFG_PARITY_EN SHALL select the parity variant.
REQ-029 With CBY_CFG_PARITY_EN defined: chain length = L+1; the extra bit is the last bit shifted in; the check passes when XOR of all L+1 bits = 0 (even parity).
REQ-030 Without CBY_CFG_PARITY_EN: chain length = L, with no parity check; only the count condition applies.

Verification
REQ-031 Default params, no parity: shift 27 bits setting mux 0 sel=2 and others 0, drop enable; drive bottom_in[1]=1 -> next cycle cfg_active=1, ipin_out[0]=1, cfg_err=0.
REQ-032 Shift 26 bits then drop enable -> cfg_err=1, cfg_active and ipin_out unchanged; repeat with 28 bits -> cfg_err=1.
REQ-033 Mux 3 sel=5, top_in[5]=1, others 0 -> ipin_out[3]=1; sel=7 -> ipin_out[3]=0.
REQ-034 Active config loaded, second session in progress -> ipin_out stable every cycle until commit; ccff_tail reproduces ccff_head delayed by 27 shifts.
REQ-035 CBY_CFG_PARITY_EN: 28 bits, odd parity -> cfg_err=1, no commit; even parity -> commit.
REQ-036 pReset asserted mid-session together with config_enable=1 -> all outputs 0, cfg_active=0; CHAN_W=16, NUM_IPIN=4, MUX_SIZE=8 build passes REQ-031 analogue.
